data_memory_sync: RTL
=====================

# data_memory_sync

Clocked, parametrised single-port data memory for the CPU datapath, replacing the combinational 4-bit/16-entry store. Accepts one read or write request per cycle through a valid/ready handshake and returns read data after a fixed, parameterised latency. After reset, a hardware sequencer zero-fills the array, so contents are deterministic without simulation-only initialisation. Sits between the CPU load/store stage and the register-file write-back path.

## Interface
- DATA_WIDTH, default 4: word width in bits.
- ADDR_WIDTH, default 4: address width; DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, default 1: cycles from read acceptance to rsp_valid; legal range 1..3.
- INIT_CLEAR, default 1: 1 = zero-fill the array after reset; 0 = skip the fill and retain contents.

- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present this cycle.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read; qualified by req_valid.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  rsp_rdata holds read data for one cycle.
- rsp_rdata  output  DATA_WIDTH  read data.
- init_busy  output  1  zero-fill in progress.

## Operation
- Accept: a request is accepted on an edge where req_valid && req_ready. Requests presented while req_ready=0 are ignored, not queued.
- FSM states:
  - CLEAR: writes 0 to address clr_cnt, then increments clr_cnt. On the edge that writes DEPTH-1, moves to RUN.
  - RUN: normal operation.
  - On reset: go to CLEAR with clr_cnt=0 if INIT_CLEAR=1, otherwise go to RUN.
- req_ready = (state==RUN) and not reset. init_busy = (state==CLEAR).
- Write:
  - On the acceptance edge, array[req_addr] <= req_wdata.
  - Writes produce no response.
- Read:
  - On the acceptance edge, array[req_addr] is sampled into stage 1 of a READ_LATENCY-deep valid/data shift pipeline.
  - rsp_valid and rsp_rdata are driven from the last stage.
  - Each read produces exactly one rsp_valid pulse. Responses return in request order and cannot be back-pressured.
- Write followed by a read of the same address on the next cycle returns the new data.
- Address wrap: all ADDR_WIDTH-bit addresses are valid; there is no out-of-range condition.
- Reset mid-operation:
  - The pipeline valid bits clear, so in-flight reads are dropped and produce no response.
  - If INIT_CLEAR=1, the fill restarts from address 0.
  - A write accepted on the same edge that reset is asserted is not performed.
- Stall: req_ready stays 1 in RUN, so throughput is one request per cycle.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_busy=INIT_CLEAR, clr_cnt=0, pipeline valid bits 0.
- INIT_CLEAR=1:
  - With reset deasserted at edge R, fill writes occur at edges R+1 .. R+DEPTH.
  - req_ready=1 and init_busy=0 in the cycle after edge R+DEPTH.
- INIT_CLEAR=0: req_ready=1 in the cycle after edge R.
- Read accepted at edge T: rsp_valid=1 during the cycle following edge T+READ_LATENCY-1, i.e. READ_LATENCY cycles after the request cycle.
- Write accepted at edge T: data is visible to a read accepted at edge T+1 or later.
- rsp_rdata is held at its last value when rsp_valid=0.

## Test plan
- Reset fill, defaults: assert reset for 2 cycles, then release. Required: init_busy=1 for exactly 16 cycles, then req_ready=1. Reads of addresses 0..15 all return 0x0.
- Write/read back: write 0x1 to address 1 and 0x2 to address 2 on back-to-back cycles, then read address 2 on the next cycle. Required: rsp_valid one cycle later with rsp_rdata=0x2, and address 1 reads 0x1.
- Latency and throughput, READ_LATENCY=3 with DATA_WIDTH=8, ADDR_WIDTH=6: write 0xA5 to 63 and 0x3C to 0, then issue 4 consecutive reads (63, 0, 63, 0). Required: 4 consecutive rsp_valid pulses starting 3 cycles after the first read, data 0xA5, 0x3C, 0xA5, 0x3C.
- Requests during fill: hold req_valid=1 with a write of 0xF to address 5 throughout CLEAR. Required: the write is ignored and address 5 reads 0x0 after the fill.
- Reset mid-flight, READ_LATENCY=2: issue a read, assert reset on the next edge. Required: no rsp_valid pulse, and the fill restarts at address 0 (16 cycles of init_busy).
- INIT_CLEAR=0: write 0x7 to address 3, pulse reset, then read address 3. Required: req_ready=1 one cycle after reset release, and rsp_rdata=0x7.

Source files
------------

// File: rtl/data_memory_sync_if.sv
// Request/response bus between the CPU load/store stage and data_memory_sync.
// The master drives the requests. The memory (slave) drives ready, the read
// response and the fill status.
interface data_memory_sync_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  init_busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, init_busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, init_busy
    );
endinterface

// File: rtl/data_memory_sync.sv
// Clocked single-port data memory with a valid/ready request port and a
// fixed-latency read response pipeline. After reset, the array can be
// zero-filled by a hardware sequencer.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_CLEAR | writing 0 to clr_cnt each cycle; requests are not accepted
// ST_RUN   | normal operation, one request accepted per cycle
module data_memory_sync #(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_LATENCY = 1,
    parameter int INIT_CLEAR   = 1
) (
    input  logic              clk,
    input  logic              reset,
    data_memory_sync_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] clr_cnt_next;
    logic                  fill_we;
    logic                  ready;
    logic                  busy;
    logic                  accept;
    logic                  wr_accept;
    logic                  rd_accept;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

    // State register and fill address counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Next state, fill strobe and handshake outputs. Ready is masked by reset
    // so a write coinciding with reset is never performed.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        fill_we      = 1'b0;
        ready        = 1'b0;
        busy         = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy         = 1'b1;
                fill_we      = !reset;
                clr_cnt_next = clr_cnt + ADDR_WIDTH'(1);
                if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                ready = !reset;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign accept    = bus.req_valid && ready;
    assign wr_accept = accept && bus.req_write;
    assign rd_accept = accept && !bus.req_write;

    // Storage array: the fill sequencer and accepted writes never coincide.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_accept) begin
            mem[bus.req_addr] <= bus.req_wdata;
        end
    end

    // Read pipeline. A data stage loads only alongside a valid beat, so the
    // last stage holds the previous response while rsp_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_accept;
            if (rd_accept) begin
                pipe_data[0] <= mem[bus.req_addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.init_busy = busy;
    assign bus.rsp_valid = pipe_vld[READ_LATENCY-1];
    assign bus.rsp_rdata = pipe_data[READ_LATENCY-1];
endmodule
